// File: rtl/zeroheti_obi_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : zeroheti_obi_apb_bridge
//  Brief    : Single-outstanding OBI-to-APB bridge with ACCESS-phase timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module zeroheti_obi_apb_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [AddrWidth-1:0] obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [3:0]           obi_be_i,
  input  logic [DataWidth-1:0] obi_wdata_i,
  output logic                 obi_rvalid_o,
  output logic [DataWidth-1:0] obi_rdata_o,
  output logic                 obi_err_o,
  output logic [AddrWidth-1:0] apb_paddr_o,
  output logic                 apb_psel_o,
  output logic                 apb_penable_o,
  output logic                 apb_pwrite_o,
  output logic [3:0]           apb_pstrb_o,
  output logic [DataWidth-1:0] apb_pwdata_o,
  output logic [2:0]           apb_pprot_o,
  input  logic                 apb_pready_i,
  input  logic [DataWidth-1:0] apb_prdata_i,
  input  logic                 apb_pslverr_i
);

  // A disabled timeout still needs a legal (1-bit) counter.
  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   paddr_q;
  logic                   pwrite_q;
  logic [3:0]             pstrb_q;
  logic [DataWidth-1:0]   pwdata_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   rvalid_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   err_q;
  logic [CntWidth-1:0]    cnt_q;

  assign obi_gnt_o     = obi_req_i && (state_q == IDLE);
  assign obi_rvalid_o  = rvalid_q;
  assign obi_rdata_o   = rdata_q;
  assign obi_err_o     = err_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pstrb_o   = pstrb_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pprot_o   = 3'b000;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= '0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (obi_req_i) begin
            // Word-align by masking so every address bit is consumed.
            paddr_q  <= obi_addr_i & ~AddrWidth'(3);
            pwrite_q <= obi_we_i;
            pstrb_q  <= obi_we_i ? obi_be_i : 4'b0000;
            pwdata_q <= obi_we_i ? obi_wdata_i : '0;
            psel_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apb_pready_i) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= apb_pslverr_i;
            rdata_q   <= (!pwrite_q && !apb_pslverr_i) ? apb_prdata_i : '0;
            state_q   <= RESP;
          end else if ((TimeoutCycles != 0) && (cnt_q == CntLimit)) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= '0;
            state_q   <= RESP;
          end else if (cnt_q != {CntWidth{1'b1}}) begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
          err_q    <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/zeroheti_obi_apb_bridge.md
ZEROHETI_OBI_APB_BRIDGE -- requirements
Module: zeroheti_obi_apb_bridge

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, OBI/APB address width.
REQ-002 SHALL have parameter DataWidth, default 32, OBI/APB data width; only 32 is supported.
REQ-003 SHALL have parameter TimeoutCycles, default 255, ACCESS-phase cycle limit before an error response; 0 disables the timeout.
REQ-004 SHALL have ports, one per line:
 clk_i  in  1  single clock, all logic rising-edge.
 rst_i  in  1  synchronous reset, active-high.
 obi_req_i  in  1  OBI request.
 obi_gnt_o  out  1  OBI grant.
 obi_addr_i  in  AddrWidth  byte address.
 obi_we_i  in  1  1 = write.
 obi_be_i  in  4  byte enables.
 obi_wdata_i  in  32  write data.
 obi_rvalid_o  out  1  response valid.
 obi_rdata_o  out  32  read data.
 obi_err_o  out  1  response error.
 apb_paddr_o  out  AddrWidth  APB address.
 apb_psel_o  out  1  APB select.
 apb_penable_o  out  1  APB enable.
 apb_pwrite_o  out  1  APB direction.
 apb_pstrb_o  out  4  APB write strobes.
 apb_pwdata_o  out  32  APB write data.
 apb_pprot_o  out  3  APB protection, constant 3'b000.
 apb_pready_i  in  1  APB ready.
 apb_prdata_i  in  32  APB read data.
 apb_pslverr_i  in  1  APB slave error.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-006 obi_gnt_o SHALL equal obi_req_i AND (state == IDLE), combinationally; one outstanding transaction max.
REQ-007 On grant, SHALL register addr, we, be, wdata and go to SETUP next cycle.
REQ-008 apb_paddr_o SHALL be registered {addr[AddrWidth-1:2], 2'b00}.
REQ-009 apb_pstrb_o SHALL be the registered be for writes, 4'b0000 for reads.
REQ-010 apb_pwdata_o SHALL be the registered wdata for writes, 0 for reads.
REQ-011 SETUP: psel=1, penable=0; unconditionally go to ACCESS next cycle.
REQ-012 ACCESS: psel=1, penable=1; paddr, pwrite, pstrb, pwdata SHALL stay stable until exit.
REQ-013 ACCESS with pready=1: capture prdata (reads only; 0 for writes) and pslverr; go to RESP; psel/penable SHALL be 0 from the next cycle.
REQ-014 A cycle counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0; width $clog2(TimeoutCycles+1), saturating, never wrapping.
REQ-015 If TimeoutCycles!=0, counter == TimeoutCycles and pready=0: abort, go to RESP with err=1, rdata=0.
REQ-016 pready=1 in the same cycle the counter reaches the limit SHALL take priority over the timeout (normal completion).
REQ-017 RESP: obi_rvalid_o=1 for exactly one cycle with captured rdata and err; next state IDLE; obi_gnt_o=0 in RESP.
REQ-018 pslverr=1 SHALL give obi_err_o=1 and obi_rdata_o=0.
REQ-019 obi_rdata_o and obi_err_o SHALL be 0 whenever obi_rvalid_o=0.
REQ-020 Minimum latency: grant cycle T, SETUP T+1, ACCESS T+2, rvalid T+3; each pready=0 cycle adds one.
REQ-021 OBI inputs SHALL be ignored outside the grant cycle.

Reset
REQ-022 With rst_i=1 at a clock edge: state=IDLE, counter=0; gnt follows REQ-006; all other outputs 0, including pprot.
REQ-023 Reset during SETUP/ACCESS/RESP SHALL abandon the transfer: psel, penable, rvalid low the next cycle; no response issued.

Verification
REQ-024 Read 0x1000_0004, pready=1 in first ACCESS, prdata=0xDEAD_BEEF -> gnt T, psel T+1..T+2, penable T+2, rvalid T+3, rdata=0xDEAD_BEEF, err=0.
REQ-025 Write addr 0x1000_0007, be=4'b0110, wdata=0x1234_5678, pready after 3 wait cycles -> paddr=0x1000_0004, pstrb=4'b0110, pwrite=1 stable 4 ACCESS cycles, rvalid T+6, rdata=0, err=0.
REQ-026 Read with pslverr=1, prdata=0xFFFF_FFFF -> rvalid with err=1, rdata=0.
REQ-027 TimeoutCycles=4, pready held 0 -> 5 ACCESS cycles, psel drops, rvalid err=1; repeat with pready=1 on the 5th ACCESS cycle -> err=0.
REQ-028 Back-to-back requests with obi_req_i held high -> gnt only in IDLE, second grant at T+4, no overlapping psel.
REQ-029 rst_i=1 during ACCESS -> next cycle psel=0, penable=0, rvalid=0, state IDLE, new request granted immediately.
